// File: rtl/key_debounce_reader.sv
// Push-button front end: polarity fix, two-flop synchroniser, debounce counter,
// and a hold FSM producing press/release/long-press strobes plus a press counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RELEASED  | debounced key is up; waiting for an accepted press
// ST_PRESSED   | key accepted down; hcnt counting towards the long-press mark
// ST_LONG_HELD | long_pulse already issued; hcnt frozen until release
module key_debounce_reader #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_active,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CYCLES - 1);
    localparam bit PARAMS_OK = (CLK_HZ > 0) && (DEBOUNCE_CYCLES >= 2) && (LONG_CYCLES >= 1);

    // Marker block that only elaborates for an out-of-range configuration.
    if (!PARAMS_OK) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    logic          p;
    logic          s1_q, s1_d;
    logic          s_q, s_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          key_level_q, key_level_d;
    logic          acc_press, acc_release;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          long_pulse_q, long_pulse_d;
    logic          long_active_q, long_active_d;
    logic [7:0]    press_count_q, press_count_d;

    assign p = key_in ^ ACTIVE_LOW;

    always_comb begin
        s1_d        = p;
        s_d         = s1_q;
        dcnt_d      = '0;
        key_level_d = key_level_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        // Any cycle where s agrees with the accepted level restarts the count.
        if (s_q != key_level_q) begin
            if (dcnt_q == DCNT_MAX) begin
                key_level_d = s_q;
                acc_press   = s_q;
                acc_release = ~s_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        hcnt_d          = hcnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        long_active_d   = long_active_q;
        press_count_d   = press_count_q;
        case (state_q)
            ST_RELEASED: begin
                if (acc_press) begin
                    state_d       = ST_PRESSED;
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                    hcnt_d        = '0;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins a tie with the long mark.
                if (acc_release) begin
                    state_d         = ST_RELEASED;
                    release_pulse_d = 1'b1;
                    long_active_d   = 1'b0;
                    hcnt_d          = '0;
                end else if (hcnt_q == HCNT_MAX) begin
                    state_d       = ST_LONG_HELD;
                    long_pulse_d  = 1'b1;
                    long_active_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (acc_release) begin
                    state_d         = ST_RELEASED;
                    release_pulse_d = 1'b1;
                    long_active_d   = 1'b0;
                    hcnt_d          = '0;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q            <= 1'b0;
            s_q             <= 1'b0;
            dcnt_q          <= '0;
            key_level_q     <= 1'b0;
            state_q         <= ST_RELEASED;
            hcnt_q          <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            long_active_q   <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            s1_q            <= s1_d;
            s_q             <= s_d;
            dcnt_q          <= dcnt_d;
            key_level_q     <= key_level_d;
            state_q         <= state_d;
            hcnt_q          <= hcnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            long_active_q   <= long_active_d;
            press_count_q   <= press_count_d;
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign long_active   = long_active_q;
    assign press_count   = press_count_q;

endmodule

// File: doc/key_debounce_reader.md
# key_debounce_reader

Input-side counterpart to the board LED driver: samples a raw, bouncy push-button pin and delivers a clean, debounced key state to the rest of the design. Also produces single-cycle press, release and long-press event pulses and a wrapping press counter. Sits directly behind the board button pin, in the same 50 MHz clock domain as the LED/timer logic.

## Interface
- CLK_HZ, 50_000_000, board clock frequency; documentation only, no logic depends on it.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range ≥2.
- LONG_CYCLES, 50_000_000, debounced-hold cycles before the long-press event (1 s at 50 MHz). Legal range ≥1.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous button pin.
- key_level  output  1  debounced state, 1 = pressed.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_pulse  output  1  one-cycle strobe when a press has been held LONG_CYCLES.
- long_active  output  1  high from long_pulse until the accepted release.
- press_count  output  8  count of accepted presses, wraps 255→0.

## Operation
- Polarity: key_in XORed with ACTIVE_LOW to give p (1 = pressed) before synchronisation.
- Synchroniser: two flops, s1 ← p, s ← s1. Both reset to 0 (released) so no spurious press after reset.
- Debounce counter dcnt, width $clog2(DEBOUNCE_CYCLES):
  - s == key_level: dcnt ← 0.
  - s != key_level and dcnt < DEBOUNCE_CYCLES-1: dcnt ← dcnt+1.
  - s != key_level and dcnt == DEBOUNCE_CYCLES-1: key_level ← s, dcnt ← 0.
  - Any single cycle of agreement restarts the count; a glitch must persist DEBOUNCE_CYCLES cycles to be accepted.
- Hold FSM, states RELEASED, PRESSED, LONG_HELD:
  - RELEASED → PRESSED on accepted 0→1: press_pulse=1, press_count ← press_count+1, hcnt ← 0.
  - PRESSED: hcnt increments each cycle; when hcnt == LONG_CYCLES-1 → LONG_HELD, long_pulse=1, long_active ← 1.
  - PRESSED or LONG_HELD → RELEASED on accepted 1→0: release_pulse=1, long_active ← 0, hcnt ← 0.
  - Release in the same cycle hcnt reaches LONG_CYCLES-1: release wins, no long_pulse.
  - long_pulse fires at most once per press; hcnt frozen in LONG_HELD (no wrap).
- hcnt width $clog2(LONG_CYCLES+1).
- All outputs registered.

## Timing
- Reset (rst high at an edge): s1, s, dcnt, hcnt, key_level, press_pulse, release_pulse, long_pulse, long_active, press_count all 0; FSM RELEASED. rst dominates all other activity.
- Latency: edge 0 = first edge registering a new stable key_in into s1. key_level, and the matching press_pulse/release_pulse, change on edge DEBOUNCE_CYCLES+1, high for exactly one cycle.
- long_pulse: if press_pulse is high after edge P, long_pulse is high after edge P+LONG_CYCLES, one cycle.
- press_count updates on the same edge as press_pulse.
- Reset mid-press with button still held: after rst drops, s goes to 1 after 2 edges and a fresh press (press_pulse, press_count=1) is reported after the full debounce. No release_pulse is emitted for the interrupted press.
- Button held through reset release with ACTIVE_LOW=1: treated as new press, as above.

## Test plan
Config for all: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
- Clean press: key_in 1→0 registered at edge 0 -> key_level=1 and press_pulse=1 after edge 5 only, press_count=1; release 0→1 -> release_pulse one cycle after its edge 5, key_level=0, no long_pulse.
- Bounce rejection: key_in low for 3 cycles, high 1, low 3, high -> key_level stays 0, no pulses, press_count=0. Low for 4 cycles -> press accepted.
- Long press: hold 20 cycles past press_pulse -> long_pulse exactly 10 cycles after press_pulse, single cycle; long_active=1 until release_pulse, then 0.
- Release/long tie: release timed so the accepted release lands on hcnt==9 -> release_pulse=1, long_pulse never asserted, long_active=0.
- Counter wrap: 256 clean presses -> press_count 255→0 on the 256th, press_pulse still fires.
- Reset mid-press: rst asserted for 1 cycle while key_level=1 and long_active=1, key still held -> all outputs 0 after rst edge. press_pulse again 6 edges after rst released, press_count=1, no release_pulse.
